// File: rtl/imm_narrower.sv
// imm_narrower: narrows signed 16-bit words to 5-bit immediates (saturate or
// wrap per word), queues them in a 2-entry FIFO with valid/ready handshakes on
// both sides, and keeps a saturating count of out-of-range words accepted.
module imm_narrower (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        sat_en,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_imm,
    output logic        out_ovf,
    output logic [7:0]  ovf_count,
    input  logic        clr_count
);

    logic [4:0] mem_imm [2];
    logic       mem_ovf [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] occ;

    logic       push;
    logic       pop;
    logic       fits;
    logic [4:0] nar_imm;

    // Handshake flags depend only on registered occupancy
    always_comb begin
        in_ready  = (occ < 2'd2);
        out_valid = (occ != 2'd0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Narrowing of the incoming word, evaluated at push time
    always_comb begin
        fits    = (&in_data[15:4]) || (~|in_data[15:4]);
        nar_imm = in_data[4:0];
        if (!fits && sat_en) begin
            nar_imm = in_data[15] ? 5'b10000 : 5'b01111;
        end
    end

    // Head entry, forced to zero while the FIFO is empty
    always_comb begin
        out_imm = '0;
        out_ovf = 1'b0;
        if (out_valid) begin
            out_imm = mem_imm[rd_ptr];
            out_ovf = mem_ovf[rd_ptr];
        end
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            occ    <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem_imm[wr_ptr] <= nar_imm;
                mem_ovf[wr_ptr] <= ~fits;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Saturating overflow counter; clear wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (reset || clr_count) begin
            ovf_count <= '0;
        end else if (push && !fits && (ovf_count != 8'hFF)) begin
            ovf_count <= ovf_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_imm_narrower.sv
// tb_imm_narrower: directed stimulus with an arithmetic reference model of the
// narrowing FIFO, a per-cycle compare process and literal spot checks.
module tb_imm_narrower;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        sat_en = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_imm;
    logic        out_ovf;
    logic [7:0]  ovf_count;
    logic        clr_count = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    imm_narrower dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sat_en    (sat_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_ovf   (out_ovf),
        .ovf_count (ovf_count),
        .clr_count (clr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Entries hold {imm, ovf} plus the source word for the sign-extension invariant.
    logic [5:0]  mq[$];
    logic [15:0] srcq[$];
    int          m_cnt = 0;
    bit          m_on = 0;
    bit          m_fresh = 0;

    function automatic logic [5:0] narrow(input logic [15:0] d, input logic s);
        int v;
        logic [4:0] imm;
        bit fit;
        v   = int'($signed(d));
        fit = (v >= -16) && (v <= 15);
        imm = v[4:0];
        if (!fit && s) imm = (v < 0) ? 5'b10000 : 5'b01111;
        return {imm, ~fit};
    endfunction

    always @(posedge clk) begin
        bit do_push, do_pop;
        logic [5:0] e;
        if (reset) begin
            mq.delete();
            srcq.delete();
            m_cnt   = 0;
            m_on    = 1;
            m_fresh = 1;
        end else if (m_on) begin
            do_push = in_valid && (mq.size() < 2);
            do_pop  = out_ready && (mq.size() > 0);
            e = narrow(in_data, sat_en);
            if (do_pop) begin
                void'(mq.pop_front());
                void'(srcq.pop_front());
            end
            if (do_push) begin
                mq.push_back(e);
                srcq.push_back(in_data);
                m_fresh = 0;
            end
            if (clr_count) m_cnt = 0;
            else if (do_push && e[0] && m_cnt < 255) m_cnt++;
        end
    end

    // ---------------- per-cycle compare + consumed log ----------------
    logic [5:0] plog[$];

    always @(negedge clk) begin
        if (m_on && !reset) begin
            chk("out_valid", int'(out_valid), int'(mq.size() > 0));
            chk("in_ready", int'(in_ready), int'(mq.size() < 2));
            chk("ovf_count", int'(ovf_count), m_cnt);
            if (mq.size() > 0) begin
                chk("head_imm", int'(out_imm), int'(mq[0][5:1]));
                chk("head_ovf", int'(out_ovf), int'(mq[0][0]));
                if (!mq[0][0])
                    chk("sext_invariant", int'({{11{out_imm[4]}}, out_imm}), int'(srcq[0]));
            end else if (m_fresh) begin
                chk("empty_imm", int'(out_imm), 0);
                chk("empty_ovf", int'(out_ovf), 0);
            end
            if (out_valid && out_ready) plog.push_back({out_imm, out_ovf});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [15:0] d, input logic s);
        in_valid = 1'b1;
        in_data  = d;
        sat_en   = s;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        step();
        step();
        reset = 1'b0;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_imm", int'(out_imm), 0);
        chk("rst_ovf_count", int'(ovf_count), 0);

        // single in-range word, one-cycle latency
        out_ready = 1'b1;
        put(16'h000F, 1'b0);
        chk("p1_valid", int'(out_valid), 1);
        chk("p1_imm", int'(out_imm), 5'b01111);
        chk("p1_ovf", int'(out_ovf), 0);
        chk("p1_cnt", int'(ovf_count), 0);
        repeat (2) step();

        // saturate, saturate, wrap
        plog.delete();
        put(16'h0010, 1'b1);
        put(16'hFFEF, 1'b1);
        put(16'h0031, 1'b0);
        repeat (3) step();
        chk("p2_n", plog.size(), 3);
        if (plog.size() == 3) begin
            chk("p2_e0", int'(plog[0]), int'({5'b01111, 1'b1}));
            chk("p2_e1", int'(plog[1]), int'({5'b10000, 1'b1}));
            chk("p2_e2", int'(plog[2]), int'({5'b10001, 1'b1}));
        end
        chk("p2_cnt", int'(ovf_count), 3);

        // fill to two entries with consumer stalled
        plog.delete();
        out_ready = 1'b0;
        put(16'hFFF0, 1'b1);
        put(16'h0001, 1'b1);
        chk("p3_full", int'(in_ready), 0);
        put(16'h0055, 1'b1);
        out_ready = 1'b1;
        repeat (3) step();
        chk("p3_n", plog.size(), 2);
        if (plog.size() == 2) begin
            chk("p3_e0", int'(plog[0]), int'({5'b10000, 1'b0}));
            chk("p3_e1", int'(plog[1]), int'({5'b00001, 1'b0}));
        end
        chk("p3_cnt", int'(ovf_count), 3);

        // streaming at occupancy 1
        plog.delete();
        out_ready = 1'b0;
        put(16'h0000, 1'b0);
        out_ready = 1'b1;
        for (int i = 1; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i);
            step();
            chk("p4_ready", int'(in_ready), 1);
        end
        in_valid = 1'b0;
        repeat (2) step();
        chk("p4_n", plog.size(), 10);
        for (int i = 0; i < plog.size(); i++)
            chk("p4_order", int'(plog[i]), i << 1);

        // counter saturation, then clear beating a same-cycle increment
        in_valid = 1'b1;
        in_data  = 16'h4000;
        sat_en   = 1'b1;
        repeat (300) step();
        chk("p5_sat", int'(ovf_count), 255);
        clr_count = 1'b1;
        step();
        clr_count = 1'b0;
        in_valid  = 1'b0;
        chk("p5_clr", int'(ovf_count), 0);
        repeat (2) step();

        // build ovf_count=5 at occupancy 2, check stored narrowing, then reset
        put(16'h8000, 1'b1);
        put(16'h0020, 1'b0);
        put(16'h7FFF, 1'b1);
        repeat (2) step();
        out_ready = 1'b0;
        put(16'h0100, 1'b1);
        put(16'hF000, 1'b1);
        sat_en = 1'b0;
        step();
        chk("p6_cnt", int'(ovf_count), 5);
        chk("p6_full", int'(in_ready), 0);
        chk("p6_head", int'(out_imm), 5'b01111);
        reset    = 1'b1;
        in_valid = 1'b1;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("p6_rst_valid", int'(out_valid), 0);
        chk("p6_rst_ready", int'(in_ready), 1);
        chk("p6_rst_cnt", int'(ovf_count), 0);
        chk("p6_rst_imm", int'(out_imm), 0);
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Safety net against a stalled run
    initial begin
        #100000;
        n_bad++;
        $display("FAIL timeout: got no finish expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

endmodule

// File: doc/imm_narrower.md
IMM_NARROWER -- requirements
Module: imm_narrower

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: reset  input  1  synchronous, active-high reset.
REQ-003: in_valid  input  1  producer offers in_data this cycle.
REQ-004: in_ready  output  1  block can accept a word this cycle.
REQ-005: in_data  input  16  signed 16-bit value to narrow to a 5-bit immediate.
REQ-006: sat_en  input  1  1 = saturate out-of-range values; 0 = truncate to bits [4:0]; sampled with each accepted word.
REQ-007: out_valid  output  1  head entry available on out_imm/out_ovf.
REQ-008: out_ready  input  1  consumer takes head entry this cycle.
REQ-009: out_imm  output  5  signed 5-bit immediate of head entry.
REQ-010: out_ovf  output  1  head entry's source value was outside [-16, +15].
REQ-011: ovf_count  output  8  saturating count of accepted out-of-range words.
REQ-012: clr_count  input  1  synchronous clear of ovf_count.

Function
REQ-013: Block SHALL hold a 2-entry FIFO of {imm[4:0], ovf}; occupancy 0..2.
REQ-014: in_ready SHALL equal (occupancy < 2), registered-state only; no combinational path from out_ready.
REQ-015: Push SHALL occur iff in_valid && in_ready; pop SHALL occur iff out_valid && out_ready.
REQ-016: out_valid SHALL equal (occupancy > 0); out_imm/out_ovf SHALL show the oldest entry.
REQ-017: Latency: word pushed at edge N into an empty FIFO SHALL appear with out_valid=1 after edge N (1 cycle).
REQ-018: Fit test: value fits iff in_data[15:4] are all equal; ovf = not fits.
REQ-019: Fits: imm = in_data[4:0] regardless of sat_en.
REQ-020: Not fits, sat_en=1: imm = 5'b01111 (+15) if in_data[15]=0, 5'b10000 (-16) if in_data[15]=1.
REQ-021: Not fits, sat_en=0: imm = in_data[4:0] (wrap).
REQ-022: Narrowing SHALL be computed at push time; later sat_en changes SHALL NOT alter stored entries.
REQ-023: Simultaneous push and pop at occupancy 1: occupancy stays 1, new entry becomes head on next cycle; order preserved.
REQ-024: Pop at occupancy 0 or push at occupancy 2 SHALL be impossible by construction (out_valid/in_ready gating); FIFO contents unchanged.
REQ-025: ovf_count SHALL increment by 1 on each push with ovf=1, saturating at 255 (no wrap).
REQ-026: clr_count=1 SHALL set ovf_count to 0 on next edge, taking priority over a same-cycle increment.
REQ-027: Invariant: for every entry with ovf=0, sign-extending imm to 16 bits SHALL equal the pushed in_data.
REQ-028: Pointers SHALL wrap modulo 2; entry order SHALL be strict FIFO across wrap.

Reset
REQ-029: reset=1 at an edge SHALL set occupancy=0, read/write pointers=0, ovf_count=0; next cycle out_valid=0, in_ready=1.
REQ-030: reset SHALL take priority over push, pop and clr_count in the same cycle; entries in flight are discarded.
REQ-031: out_imm/out_ovf SHALL read 0 while occupancy=0 after reset.

Verification
REQ-032: Push 16'h000F, sat_en=x, out_ready=1 -> next cycle out_valid=1, out_imm=5'b01111, out_ovf=0; ovf_count=0.
REQ-033: Push 16'h0010 sat_en=1, then 16'hFFEF sat_en=1, then 16'h0031 sat_en=0 -> out_imm 5'b01111/ovf=1, 5'b10000/ovf=1, 5'b10001/ovf=1 in order; ovf_count=3.
REQ-034: out_ready=0, push 16'hFFF0 and 16'h0001 -> in_ready=0 after second push; third in_valid ignored; then out_ready=1 -> 5'b10000 then 5'b00001, ovf=0 both.
REQ-035: Occupancy 1, push and pop same cycle repeatedly for 10 cycles with incrementing 0..9 -> outputs 0..9 in order, in_ready never drops.
REQ-036: 300 out-of-range pushes -> ovf_count holds 255; clr_count asserted with an overflow push in same cycle -> ovf_count=0.
REQ-037: Occupancy 2, ovf_count=5, assert reset with in_valid=1 and clr_count=0 -> next cycle out_valid=0, in_ready=1, ovf_count=0.
